// File: rtl/phy_rx_lane_ctrl.sv
// ============================================================================
// phy_rx_lane_ctrl
//
// Purpose:
//   Two-lane receive controller for a byte-striped PHY link. It brings the
//   link up once both lanes report comma lock, buffers each lane in a small
//   2-entry FIFO, and de-stripes the lanes back into one byte stream by
//   strictly alternating lane 0, lane 1, lane 0, ... It drops into a sticky
//   FAIL state on lock timeout, loss of lock, or FIFO overflow.
//
// Ports:
//   clk_4f     in   1  byte-rate clock, all state updates on its rising edge
//   reset_L    in   1  asynchronous active-low reset
//   data_in0   in   8  lane-0 byte from its serial-to-parallel converter
//   valid_in0  in   1  lane-0 byte qualifier
//   active0    in   1  lane-0 comma-lock indicator
//   data_in1   in   8  lane-1 byte
//   valid_in1  in   1  lane-1 byte qualifier
//   active1    in   1  lane-1 comma-lock indicator
//   restart    in   1  synchronous request to re-run link bring-up
//   data_out   out  8  de-striped byte stream
//   valid_out  out  1  data_out qualifier
//   link_up    out  1  high only in RUN
//   error      out  1  high only in FAIL
//   state      out  2  current FSM state (IDLE=00, WAIT=01, RUN=10, FAIL=11)
//
// Parameters:
//   TIMEOUT_CYC  cycles allowed in WAIT for both lanes to lock (1..255)
// ============================================================================
module phy_rx_lane_ctrl #(
    parameter int TIMEOUT_CYC = 200
) (
    input  logic       clk_4f,
    input  logic       reset_L,
    input  logic [7:0] data_in0,
    input  logic       valid_in0,
    input  logic       active0,
    input  logic [7:0] data_in1,
    input  logic       valid_in1,
    input  logic       active1,
    input  logic       restart,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       link_up,
    output logic       error,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RUN  = 2'b10,
        ST_FAIL = 2'b11
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ptr_q, ptr_d;
    logic [7:0] data_d;
    logic       valid_d;
    logic       link_d;
    logic       error_d;

    // Per-lane FIFO: head is the next byte to leave, tail the second entry.
    logic [7:0] head_q  [2];
    logic [7:0] head_d  [2];
    logic [7:0] tail_q  [2];
    logic [7:0] tail_d  [2];
    logic [1:0] count_q [2];
    logic [1:0] count_d [2];

    logic [7:0] din  [2];
    logic [1:0] push;
    logic [1:0] pop;
    logic       overflow;
    logic       both_active;

    assign din[0]      = data_in0;
    assign din[1]      = data_in1;
    assign push        = {valid_in1, valid_in0};
    assign both_active = active0 & active1;
    assign state       = state_q;

    // A lane can only be popped when the alternation pointer selects it, so
    // a push to a full FIFO is only safe on the lane being popped this cycle.
    always_comb begin
        overflow = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pop[i] = (ptr_q == i[0]) && (count_q[i] != 2'd0);
            if (push[i] && (count_q[i] == 2'd2) && !pop[i]) begin
                overflow = 1'b1;
            end
        end
    end

    // Next-state and next-output logic. Any fault in RUN leaves the FIFOs
    // untouched and suppresses the pop, so the overflowing byte is dropped
    // and nothing more reaches the output.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        data_d  = data_out;
        valid_d = 1'b0;
        for (int i = 0; i < 2; i++) begin
            head_d[i]  = head_q[i];
            tail_d[i]  = tail_q[i];
            count_d[i] = count_q[i];
        end

        if (restart) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
            ptr_d   = 1'b0;
            for (int i = 0; i < 2; i++) begin
                count_d[i] = 2'd0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT;
                    cnt_d   = 8'd0;
                end
                ST_WAIT: begin
                    cnt_d = cnt_q + 8'd1;
                    if (both_active) begin
                        state_d = ST_RUN;
                        ptr_d   = 1'b0;
                        for (int i = 0; i < 2; i++) begin
                            count_d[i] = 2'd0;
                        end
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d = ST_FAIL;
                    end
                end
                ST_RUN: begin
                    if (!both_active || overflow) begin
                        state_d = ST_FAIL;
                    end else begin
                        for (int i = 0; i < 2; i++) begin
                            case (count_q[i])
                                2'd0: begin
                                    if (push[i]) begin
                                        head_d[i]  = din[i];
                                        count_d[i] = 2'd1;
                                    end
                                end
                                2'd1: begin
                                    if (push[i] && pop[i]) begin
                                        head_d[i] = din[i];
                                    end else if (push[i]) begin
                                        tail_d[i]  = din[i];
                                        count_d[i] = 2'd2;
                                    end else if (pop[i]) begin
                                        count_d[i] = 2'd0;
                                    end
                                end
                                default: begin
                                    // Full: only reachable with a pop, since
                                    // push-without-pop is an overflow.
                                    if (pop[i]) begin
                                        head_d[i] = tail_q[i];
                                        if (push[i]) begin
                                            tail_d[i] = din[i];
                                        end else begin
                                            count_d[i] = 2'd1;
                                        end
                                    end
                                end
                            endcase
                        end
                        if (pop[ptr_q]) begin
                            data_d  = head_q[ptr_q];
                            valid_d = 1'b1;
                            ptr_d   = ~ptr_q;
                        end
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        link_d  = (state_d == ST_RUN);
        error_d = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            ptr_q     <= 1'b0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            link_up   <= 1'b0;
            error     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                head_q[i]  <= 8'h00;
                tail_q[i]  <= 8'h00;
                count_q[i] <= 2'd0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            data_out  <= data_d;
            valid_out <= valid_d;
            link_up   <= link_d;
            error     <= error_d;
            for (int i = 0; i < 2; i++) begin
                head_q[i]  <= head_d[i];
                tail_q[i]  <= tail_d[i];
                count_q[i] <= count_d[i];
            end
        end
    end

endmodule

// File: tb/tb_phy_rx_lane_ctrl.sv
// ============================================================================
// tb_phy_rx_lane_ctrl
//
// Purpose:
//   Self-checking bench for phy_rx_lane_ctrl. A queue-based reference model
//   tracks the link mode and the per-lane byte backlogs and predicts every
//   output after each clock edge. Directed scenarios cover bring-up, lock
//   timeout, ordered de-striping, overflow, loss of lock and asynchronous
//   reset; a randomized phase then exercises arbitrary traffic.
// ============================================================================
module tb_phy_rx_lane_ctrl;

    localparam int TMO = 10;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_RUN  = 2;
    localparam int M_FAIL = 3;

    logic       clk_4f;
    logic       reset_L;
    logic [7:0] data_in0;
    logic       valid_in0;
    logic       active0;
    logic [7:0] data_in1;
    logic       valid_in1;
    logic       active1;
    logic       restart;
    logic [7:0] data_out;
    logic       valid_out;
    logic       link_up;
    logic       error;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int         m_mode;
    int         m_wait_cycles;
    int         m_next_lane;
    logic [7:0] m_lane0 [$];
    logic [7:0] m_lane1 [$];
    logic [7:0] m_data;
    logic       m_valid;

    logic [7:0] seen [$];

    phy_rx_lane_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .clk_4f    (clk_4f),
        .reset_L   (reset_L),
        .data_in0  (data_in0),
        .valid_in0 (valid_in0),
        .active0   (active0),
        .data_in1  (data_in1),
        .valid_in1 (valid_in1),
        .active1   (active1),
        .restart   (restart),
        .data_out  (data_out),
        .valid_out (valid_out),
        .link_up   (link_up),
        .error     (error),
        .state     (state)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_mode        = M_IDLE;
        m_wait_cycles = 0;
        m_next_lane   = 0;
        m_lane0.delete();
        m_lane1.delete();
        m_data        = 8'h00;
        m_valid       = 1'b0;
    endtask

    // One clock edge of the link behaviour, from the inputs seen at that edge.
    task automatic modelStep();
        bit ovf0, ovf1, will_pop0, will_pop1;
        m_valid = 1'b0;
        if (restart) begin
            m_mode        = M_IDLE;
            m_wait_cycles = 0;
            m_next_lane   = 0;
            m_lane0.delete();
            m_lane1.delete();
        end else if (m_mode == M_IDLE) begin
            m_mode        = M_WAIT;
            m_wait_cycles = 0;
        end else if (m_mode == M_WAIT) begin
            m_wait_cycles++;
            if (active0 && active1) begin
                m_mode      = M_RUN;
                m_next_lane = 0;
                m_lane0.delete();
                m_lane1.delete();
            end else if (m_wait_cycles == TMO) begin
                m_mode = M_FAIL;
            end
        end else if (m_mode == M_RUN) begin
            will_pop0 = (m_next_lane == 0) && (m_lane0.size() > 0);
            will_pop1 = (m_next_lane == 1) && (m_lane1.size() > 0);
            ovf0 = valid_in0 && (m_lane0.size() == 2) && !will_pop0;
            ovf1 = valid_in1 && (m_lane1.size() == 2) && !will_pop1;
            if (!(active0 && active1) || ovf0 || ovf1) begin
                m_mode = M_FAIL;
            end else begin
                if (will_pop0) begin
                    m_data      = m_lane0.pop_front();
                    m_valid     = 1'b1;
                    m_next_lane = 1;
                end else if (will_pop1) begin
                    m_data      = m_lane1.pop_front();
                    m_valid     = 1'b1;
                    m_next_lane = 0;
                end
                if (valid_in0) m_lane0.push_back(data_in0);
                if (valid_in1) m_lane1.push_back(data_in1);
            end
        end
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, ".state"}, 32'(state), 32'(m_mode));
        checkOutput({tag, ".valid_out"}, 32'(valid_out), 32'(m_valid));
        checkOutput({tag, ".data_out"}, 32'(data_out), 32'(m_data));
        checkOutput({tag, ".link_up"}, 32'(link_up), 32'(m_mode == M_RUN));
        checkOutput({tag, ".error"}, 32'(error), 32'(m_mode == M_FAIL));
    endtask

    // Drive one cycle of inputs, clock it, advance the model and compare.
    task automatic applyStimulus(input string tag,
                                 input logic v0, input logic [7:0] d0, input logic a0,
                                 input logic v1, input logic [7:0] d1, input logic a1,
                                 input logic rs);
        valid_in0 = v0;
        data_in0  = d0;
        active0   = a0;
        valid_in1 = v1;
        data_in1  = d1;
        active1   = a1;
        restart   = rs;
        @(posedge clk_4f);
        modelStep();
        #1;
        compareAll(tag);
        if (valid_out) seen.push_back(data_out);
    endtask

    task automatic idleCycle(input string tag, input logic a0, input logic a1,
                             input logic rs);
        applyStimulus(tag, 1'b0, 8'h00, a0, 1'b0, 8'h00, a1, rs);
    endtask

    task automatic bringUp(input string tag);
        idleCycle(tag, 1'b0, 1'b0, 1'b1);
        idleCycle(tag, 1'b1, 1'b1, 1'b0);
        idleCycle(tag, 1'b1, 1'b1, 1'b0);
        checkOutput({tag, ".in_run"}, 32'(state), 32'd2);
    endtask

    initial begin
        reset_L   = 1'b0;
        data_in0  = 8'h00;
        valid_in0 = 1'b0;
        active0   = 1'b0;
        data_in1  = 8'h00;
        valid_in1 = 1'b0;
        active1   = 1'b0;
        restart   = 1'b0;
        modelReset();
        repeat (2) @(posedge clk_4f);
        #1;
        compareAll("reset");
        @(negedge clk_4f);
        reset_L = 1'b1;

        // Bring-up with lock arriving on the third edge
        idleCycle("bring_up", 1'b0, 1'b0, 1'b0);
        checkOutput("bring_up.wait", 32'(state), 32'd1);
        idleCycle("bring_up", 1'b0, 1'b0, 1'b0);
        idleCycle("bring_up", 1'b1, 1'b1, 1'b0);
        checkOutput("bring_up.run", 32'(state), 32'd2);
        checkOutput("bring_up.link", 32'(link_up), 32'd1);

        // Ordered de-striping, each lane sending every other cycle
        seen.delete();
        applyStimulus("stripe", 1'b1, 8'hA1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        idleCycle("stripe", 1'b1, 1'b1, 1'b0);
        applyStimulus("stripe", 1'b0, 8'h00, 1'b1, 1'b1, 8'hA2, 1'b1, 1'b0);
        idleCycle("stripe", 1'b1, 1'b1, 1'b0);
        applyStimulus("stripe", 1'b1, 8'hA3, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        idleCycle("stripe", 1'b1, 1'b1, 1'b0);
        applyStimulus("stripe", 1'b0, 8'h00, 1'b1, 1'b1, 8'hA4, 1'b1, 1'b0);
        repeat (3) idleCycle("stripe", 1'b1, 1'b1, 1'b0);
        checkOutput("stripe.count", 32'(seen.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("stripe.byte",
                        (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF_FFFF,
                        32'(8'hA1 + 8'(i)));
        end

        // Lane 1 alone overflows its FIFO on the third back-to-back byte
        applyStimulus("ovf", 1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0);
        applyStimulus("ovf", 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0);
        checkOutput("ovf.still_run", 32'(state), 32'd2);
        applyStimulus("ovf", 1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0);
        checkOutput("ovf.fail", 32'(state), 32'd3);
        checkOutput("ovf.valid", 32'(valid_out), 32'd0);
        repeat (2) idleCycle("ovf.stuck", 1'b1, 1'b1, 1'b0);

        // Loss of lock on lane 1 for a single cycle
        bringUp("drop");
        idleCycle("drop", 1'b1, 1'b0, 1'b0);
        checkOutput("drop.fail", 32'(state), 32'd3);
        checkOutput("drop.link", 32'(link_up), 32'd0);
        idleCycle("drop.stuck", 1'b1, 1'b1, 1'b0);

        // Lock timeout with only lane 0 locked
        idleCycle("tmo", 1'b0, 1'b0, 1'b1);
        checkOutput("tmo.idle", 32'(state), 32'd0);
        repeat (TMO) idleCycle("tmo", 1'b1, 1'b0, 1'b0);
        checkOutput("tmo.last_wait", 32'(state), 32'd1);
        idleCycle("tmo", 1'b1, 1'b0, 1'b0);
        checkOutput("tmo.fail", 32'(state), 32'd3);
        checkOutput("tmo.error", 32'(error), 32'd1);
        idleCycle("tmo.restart", 1'b1, 1'b0, 1'b1);
        checkOutput("tmo.restart_idle", 32'(state), 32'd0);
        checkOutput("tmo.restart_err", 32'(error), 32'd0);

        // Asynchronous reset while bytes are buffered
        bringUp("areset");
        applyStimulus("areset", 1'b1, 8'h5A, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0);
        applyStimulus("areset", 1'b1, 8'h5B, 1'b1, 1'b1, 8'hC4, 1'b1, 1'b0);
        #2;
        reset_L = 1'b0;
        #1;
        modelReset();
        compareAll("areset.async");
        #1;
        reset_L = 1'b1;
        seen.delete();
        idleCycle("areset.after", 1'b1, 1'b1, 1'b0);
        checkOutput("areset.wait", 32'(state), 32'd1);
        repeat (6) idleCycle("areset.after", 1'b1, 1'b1, 1'b0);
        checkOutput("areset.no_stale", 32'(seen.size()), 32'd0);

        // Randomized traffic against the model
        for (int blk = 0; blk < 30; blk++) begin
            int rate;
            rate = int'($urandom_range(15, 60));
            for (int c = 0; c < 50; c++) begin
                logic v0, v1, a0, a1, rs;
                v0 = ($urandom_range(99) < rate);
                v1 = ($urandom_range(99) < rate);
                a0 = ($urandom_range(199) != 0);
                a1 = ($urandom_range(199) != 0);
                if (m_mode == M_FAIL) rs = ($urandom_range(3) == 0);
                else                  rs = ($urandom_range(299) == 0);
                applyStimulus("rand", v0, 8'($urandom), a0, v1, 8'($urandom), a1, rs);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
